// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier sequencer: controller states,
// datapath ALU operation codes and the Booth recoding of one multiplier bit pair.
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CALC  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    // Radix-2 Booth recoding of {Q[0], Q[-1]}: 10 starts a run of ones (subtract),
    // 01 ends a run (add), 00/11 are inside a run (no operation).
    function automatic logic [1:0] booth_decode(input logic q0, input logic qm1);
        logic [1:0] op;
        op = OP_NONE;
        if (q0 && !qm1) begin
            op = OP_SUB;
        end else if (!q0 && qm1) begin
            op = OP_ADD;
        end
        return op;
    endfunction

endpackage

// File: rtl/booth_step_counter.sv
// Iteration counter for the Booth sequencer. Cleared when a new operation is
// loaded (and when a finished product is handed off), advanced once per shift.
module booth_step_counter #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Up-counter; reset and clear both return it to zero, clear wins over enable.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/booth_ctrl.sv
// Sequencing FSM for a radix-2 Booth multiplier datapath. Accepts an operand
// request, pulses the datapath load, runs WIDTH add/sub-then-shift iterations
// and offers the product {A,Q} on a valid/ready handshake. No operand arithmetic.
module booth_ctrl
    import booth_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic             q0_i,
    input  logic             qm1_i,
    output logic             load_o,
    output logic [1:0]       op_o,
    output logic             shift_o,
    output logic             done_valid_o,
    input  logic             done_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] step_o
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_step;
    logic             w_last;
    logic             w_cnt_clr;

    // The step counter is also cleared on the product handoff so that step_o
    // reads zero again once the controller is back in IDLE.
    assign w_cnt_clr = load_o | (done_valid_o & done_ready_i);
    assign w_last    = (w_step == CNT_W'(WIDTH - 1));

    booth_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clr   (w_cnt_clr),
        .i_en    (shift_o),
        .o_cnt   (w_step)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode; every strobe is owned by exactly one state.
    always_comb begin
        w_state_nxt   = r_state;
        start_ready_o = 1'b0;
        load_o        = 1'b0;
        op_o          = OP_NONE;
        shift_o       = 1'b0;
        done_valid_o  = 1'b0;
        case (r_state)
            IDLE: begin
                start_ready_o = 1'b1;
                if (start_valid_i) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                load_o      = 1'b1;
                w_state_nxt = CALC;
            end
            CALC: begin
                op_o        = booth_decode(q0_i, qm1_i);
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                shift_o     = 1'b1;
                w_state_nxt = w_last ? DONE : CALC;
            end
            DONE: begin
                done_valid_o = 1'b1;
                if (done_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy_o = (r_state != IDLE);
    assign step_o = w_step;

endmodule
